// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a start/busy/done handshake and a multi-cycle
// unsigned restoring divider.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request, sampled only while busy=0
//   op         opcode (ADD/SUB/AND/OR/EQUAL/DIVIDE/REM), sampled with start
//   in1, in2   operand A / dividend and operand B / divisor, sampled with start
//   busy       high while a divide is in flight
//   done       one-cycle pulse: out/rem/flags/div_zero were updated this cycle
//   out        result, or quotient for DIVIDE / remainder for REM
//   rem        remainder for DIVIDE, quotient for REM, zero otherwise
//   flags      {V,C,N,Z}
//   Cout       copy of flags[2]
//   div_zero   divisor was zero on the last completed DIVIDE/REM
//   dbg_state  current control state (0=IDLE, 1=DIV, 2=FIN)
//
// Handshake: a request is accepted on a rising edge where start=1 and busy=0.
// Single-cycle ops answer with done=1 in the very next cycle and never raise
// busy, so one request per cycle is sustainable. A divide raises busy from the
// accepting edge until the edge that raises done; start is ignored meanwhile.
// done and busy are never high together.
module seq_alu #(
  parameter int WIDTH = 36,
  parameter int OPW   = 5,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic [3:0]       flags,
  output logic             Cout,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  localparam logic [OPW-1:0] OP_ADD    = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB    = OPW'(1);
  localparam logic [OPW-1:0] OP_AND    = OPW'(2);
  localparam logic [OPW-1:0] OP_OR     = OPW'(3);
  localparam logic [OPW-1:0] OP_EQUAL  = OPW'(4);
  localparam logic [OPW-1:0] OP_DIVIDE = OPW'(5);
  localparam logic [OPW-1:0] OP_REM    = OPW'(6);
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_FIN = 2'd2} state_t;

  state_t           r_state;
  logic             r_busy, r_done, r_div_zero, r_is_rem;
  logic [WIDTH-1:0] r_out, r_rem;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_dvd;   // dividend, shifted left; quotient bits enter at LSB
  logic [WIDTH-1:0] r_dvs;   // divisor
  logic [WIDTH-1:0] r_prem;  // partial remainder
  logic [CNTW-1:0]  r_cnt;

  // Single-cycle datapath
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v, w_is_div;

  always_comb begin
    w_sum    = {1'b0, in1} + {1'b0, in2};
    w_diff   = {1'b0, in1} - {1'b0, in2};
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_is_div = (op == OP_DIVIDE) || (op == OP_REM);
    case (op)
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (in1[MSB] == in2[MSB]) && (w_sum[MSB] != in1[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff[MSB:0];
        w_c   = w_diff[WIDTH];  // borrow out of the extended subtract
        w_v   = (in1[MSB] != in2[MSB]) && (w_diff[MSB] != in1[MSB]);
      end
      OP_AND:    w_res = in1 & in2;
      OP_OR:     w_res = in1 | in2;
      OP_EQUAL:  w_res = {{(WIDTH-1){1'b0}}, (in1 == in2)};
      // Only reached through the divide-by-zero short path.
      OP_DIVIDE,
      OP_REM:    w_res = '1;
      default:   w_res = '0;
    endcase
  end

  // One restoring-division step
  logic [WIDTH:0]   w_shift, w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_prem_nxt, w_dvd_nxt, w_fin_out, w_fin_rem;

  always_comb begin
    w_shift    = {r_prem, r_dvd[MSB]};
    w_trial    = w_shift - {1'b0, r_dvs};
    w_ge       = (w_shift >= {1'b0, r_dvs});
    w_prem_nxt = w_ge ? w_trial[MSB:0] : w_shift[MSB:0];
    w_dvd_nxt  = {r_dvd[MSB-1:0], w_ge};
    w_fin_out  = r_is_rem ? r_prem : r_dvd;
    w_fin_rem  = r_is_rem ? r_dvd : r_prem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_out      <= '0;
      r_rem      <= '0;
      r_flags    <= '0;
      r_div_zero <= 1'b0;
      r_is_rem   <= 1'b0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_prem     <= '0;
      r_cnt      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_div && (in2 != '0)) begin
              r_dvd    <= in1;
              r_dvs    <= in2;
              r_prem   <= '0;
              r_is_rem <= (op == OP_REM);
              r_cnt    <= CNT_INIT;
              r_busy   <= 1'b1;
              r_state  <= S_DIV;
            end else begin
              r_out   <= w_res;
              r_rem   <= w_is_div ? in1 : '0;
              r_flags <= {w_v, w_c, w_res[MSB], (w_res == '0)};
              r_done  <= 1'b1;
              if (w_is_div) r_div_zero <= 1'b1;
            end
          end
        end
        S_DIV: begin
          r_prem <= w_prem_nxt;
          r_dvd  <= w_dvd_nxt;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == CNTW'(1)) r_state <= S_FIN;
        end
        S_FIN: begin
          r_out      <= w_fin_out;
          r_rem      <= w_fin_rem;
          r_flags    <= {2'b00, w_fin_out[MSB], (w_fin_out == '0)};
          r_div_zero <= 1'b0;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out       = r_out;
  assign rem       = r_rem;
  assign flags     = r_flags;
  assign Cout      = r_flags[2];
  assign div_zero  = r_div_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  localparam int W  = 36;
  localparam int EW = 2 * W + 5;  // {div_zero, flags, rem, out}

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   op = '0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic         busy, done, Cout, div_zero;
  logic [W-1:0] out, rem;
  logic [3:0]   flags;
  logic [1:0]   dbg_state;

  seq_alu #(.WIDTH(W), .OPW(5), .CNTW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .out(out), .rem(rem), .flags(flags),
    .Cout(Cout), .div_zero(div_zero), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic mdz = 1'b0;  // model of div_zero

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the operands.
  function automatic logic [EW-1:0] model(input logic [4:0] opc, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic dz_in);
    logic [W-1:0] o, r;
    logic c, v, dz;
    longint sa, sb, s, maxs, mins;
    o = '0; r = '0; c = 1'b0; v = 1'b0; dz = dz_in;
    sa = $signed(a);
    sb = $signed(b);
    maxs = (longint'(1) <<< (W - 1)) - 1;
    mins = -(longint'(1) <<< (W - 1));
    case (opc)
      5'd0: begin
        o = a + b;
        c = ({28'd0, a} + {28'd0, b}) >= (64'd1 << W);
        s = sa + sb;
        v = (s > maxs) || (s < mins);
      end
      5'd1: begin
        o = a - b;
        c = (a < b);
        s = sa - sb;
        v = (s > maxs) || (s < mins);
      end
      5'd2: o = a & b;
      5'd3: o = a | b;
      5'd4: o = (a == b) ? W'(1) : W'(0);
      5'd5, 5'd6: begin
        if (b == '0) begin
          o = '1; r = a; dz = 1'b1;
        end else begin
          o = (opc == 5'd5) ? a / b : a % b;
          r = (opc == 5'd5) ? a % b : a / b;
          dz = 1'b0;
        end
      end
      default: o = '0;
    endcase
    return {dz, v, c, o[W-1], (o == '0), r, o};
  endfunction

  // Present one request at a negedge; returns at the next negedge (after edge E).
  task automatic drive(input logic [4:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    logic [EW-1:0] e;
    start = 1'b1; op = opc; in1 = a; in2 = b;
    if (push) begin
      e = model(opc, a, b, mdz);
      mdz = e[EW-1];
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("busy_timeout", 64'(n), 64'd0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && done) begin
      check("done_with_busy", 64'(busy), 64'd0);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: out=%0h with empty expected queue", out);
      end else begin
        e = exp_q.pop_front();
        check("out", 64'(out), 64'(e[W-1:0]));
        check("rem", 64'(rem), 64'(e[2*W-1:W]));
        check("flags", 64'(flags), 64'(e[2*W+3:2*W]));
        check("cout", 64'(Cout), 64'(e[2*W+2]));
        check("div_zero", 64'(div_zero), 64'(e[EW-1]));
      end
    end
  end

  initial begin
    int n;
    logic [4:0]   ro;
    logic [W-1:0] ra, rb;
    logic [63:0]  t;

    // reset mid-cycle
    #3 rst = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_out", 64'(out), 0);
    check("rst_rem", 64'(rem), 0);
    check("rst_flags", 64'(flags), 0);
    check("rst_cout", 64'(Cout), 0);
    check("rst_div_zero", 64'(div_zero), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // ADD carry
    drive(5'd0, 36'hFFFFFFFFF, 36'd1, 1);
    start = 1'b0;
    check("add_done", 64'(done), 1);
    check("add_out", 64'(out), 0);
    check("add_flags", 64'(flags), 64'b0101);
    check("add_cout", 64'(Cout), 1);

    // SUB borrow, then SUB signed overflow
    drive(5'd1, 36'd5, 36'd7, 1);
    check("sub_out", 64'(out), 64'hFFFFFFFFE);
    check("sub_flags", 64'(flags), 64'b0110);
    drive(5'd1, 36'h7FFFFFFFF, 36'hFFFFFFFFF, 1);
    start = 1'b0;
    check("subv_out", 64'(out), 64'h800000000);
    check("subv_flags", 64'(flags), 64'b1110);

    // DIVIDE latency, then REM
    drive(5'd5, 36'd100, 36'd7, 1);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    check("div_busy_cycles", 64'(n), 37);
    check("div_done", 64'(done), 1);
    check("div_out", 64'(out), 14);
    check("div_rem", 64'(rem), 2);
    check("div_dz", 64'(div_zero), 0);
    drive(5'd6, 36'd100, 36'd7, 1);
    start = 1'b0;
    wait_idle();
    check("rem_out", 64'(out), 2);
    check("rem_rem", 64'(rem), 14);

    // divide by zero
    drive(5'd5, 36'd55, 36'd0, 1);
    start = 1'b0;
    check("dz_done", 64'(done), 1);
    check("dz_busy", 64'(busy), 0);
    check("dz_out", 64'(out), 64'hFFFFFFFFF);
    check("dz_rem", 64'(rem), 55);
    check("dz_flag", 64'(div_zero), 1);

    // start while busy is ignored
    drive(5'd5, 36'd1000, 36'd10, 1);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 5'd0; in1 = 36'd1; in2 = 36'd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("busyprot_out", 64'(out), 100);
    check("busyprot_rem", 64'(rem), 0);

    // reset mid-divide aborts with no done
    drive(5'd5, 36'd1000, 36'd10, 0);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 0);
    check("abort_out", 64'(out), 0);
    check("abort_rem", 64'(rem), 0);
    check("abort_flags", 64'(flags), 0);
    mdz = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", 64'(done), 0);
    drive(5'd0, 36'd1, 36'd1, 1);
    start = 1'b0;
    check("after_abort_out", 64'(out), 2);

    // back-to-back single-cycle ops
    drive(5'd2, 36'hF0F0, 36'hFF00, 1);
    check("b2b_and", 64'(out), 64'hF000);
    drive(5'd3, 36'hF0F0, 36'hFF00, 1);
    check("b2b_or", 64'(out), 64'hFFF0);
    drive(5'd4, 36'd9, 36'd9, 1);
    check("b2b_eq", 64'(out), 1);
    drive(5'd31, 36'd9, 36'd9, 1);
    start = 1'b0;
    check("b2b_ill_done", 64'(done), 1);
    check("b2b_ill_out", 64'(out), 0);
    check("b2b_ill_flags", 64'(flags), 64'b0001);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(0, 9);
      if (n < 8) ro = 5'(n);
      else if (n == 8) ro = 5'd31;
      else ro = 5'($urandom_range(8, 30));
      t = {$urandom(), $urandom()};
      ra = t[W-1:0];
      t = {$urandom(), $urandom()};
      rb = t[W-1:0];
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 20));
        2: ra = rb;
        default: ;
      endcase
      drive(ro, ra, rb, 1);
      if (busy) begin
        start = 1'b0;
        wait_idle();
      end else if ($urandom_range(0, 3) == 0) begin
        start = 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
